// File: rtl/proc_pkg.sv
// +----------------------------------------------------------------------------+
// | proc_pkg : shared opcode encoding and helpers for alu_pipe_proc             |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package proc_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MOV  = 3'b100,
        OP_ADDW = 3'b101,
        OP_SUBW = 3'b110,
        OP_INV  = 3'b111
    } op_e;

    function automatic logic is_writing(input op_e op);
        return (op == OP_MOV) || (op == OP_ADDW) || (op == OP_SUBW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// +----------------------------------------------------------------------------+
// | alu_core : combinational ALU producing result and SF/ZF/CF/invalid flags    |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_core
    import proc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             sf,
    output logic             zf,
    output logic             cf,
    output logic             invalid
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // The extra MSB of the widened subtraction is the borrow, i.e. a < b unsigned.
    always_comb begin
        w_sum   = {1'b0, a} + {1'b0, b};
        w_diff  = {1'b0, a} - {1'b0, b};
        result  = '0;
        cf      = 1'b0;
        invalid = 1'b0;
        case (op)
            OP_ADD, OP_ADDW: {cf, result} = w_sum;
            OP_SUB, OP_SUBW: {cf, result} = w_diff;
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            OP_MOV:          result = imm;
            default:         invalid = 1'b1;
        endcase
    end

    assign sf = result[WIDTH-1];
    assign zf = !invalid && (result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_pipe_proc.sv
// +----------------------------------------------------------------------------+
// | alu_pipe_proc : two-stage register-file ALU with valid/ready on both sides  |
// | Optional macro PROC_BYPASS_EN enables same-edge write-to-read bypass.       |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_pipe_proc
    import proc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [WIDTH-1:0] imm,
    input  logic             reg_w_enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             SF,
    output logic             ZF,
    output logic             CF,
    output logic             invalid_op
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q,    s1_op_d;
    logic             s1_wr_q,    s1_wr_d;
    logic [AW-1:0]    s1_wa_q,    s1_wa_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic [WIDTH-1:0] s1_imm_q,   s1_imm_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             sf_q, sf_d, zf_q, zf_d, cf_q, cf_d, inv_q, inv_d;

    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_sf, w_alu_zf, w_alu_cf, w_alu_inv;
    logic             w_s2_free, w_s1_adv, w_wr_en, w_accept;
    logic [WIDTH-1:0] w_opnd_a, w_opnd_b;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op      (s1_op_q),
        .a       (s1_a_q),
        .b       (s1_b_q),
        .imm     (s1_imm_q),
        .result  (w_alu_res),
        .sf      (w_alu_sf),
        .zf      (w_alu_zf),
        .cf      (w_alu_cf),
        .invalid (w_alu_inv)
    );

    assign w_s2_free = !out_valid_q || out_ready;
    assign w_s1_adv  = s1_valid_q && w_s2_free;
    assign w_wr_en   = w_s1_adv && s1_wr_q;
    assign w_accept  = in_valid && in_ready;

`ifdef PROC_BYPASS_EN
    assign in_ready = !s1_valid_q || w_s1_adv;
`else
    // A pending write blocks issue so the next read sees the committed value.
    assign in_ready = !s1_valid_q || (w_s1_adv && !s1_wr_q);
`endif

    always_comb begin
        w_opnd_a = regs_q[ra];
        w_opnd_b = regs_q[rb];
`ifdef PROC_BYPASS_EN
        if (w_wr_en && (s1_wa_q == ra)) w_opnd_a = w_alu_res;
        if (w_wr_en && (s1_wa_q == rb)) w_opnd_b = w_alu_res;
`endif
    end

    always_comb begin
        regs_d      = regs_q;
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_wr_d     = s1_wr_q;
        s1_wa_d     = s1_wa_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_imm_d    = s1_imm_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sf_d        = sf_q;
        zf_d        = zf_q;
        cf_d        = cf_q;
        inv_d       = inv_q;

        if (w_wr_en) regs_d[s1_wa_q] = w_alu_res;

        if (w_s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = w_alu_res;
                sf_d     = w_alu_sf;
                zf_d     = w_alu_zf;
                cf_d     = w_alu_cf;
                inv_d    = w_alu_inv;
            end
        end

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op_e'(opcode);
            s1_wr_d    = is_writing(op_e'(opcode)) && reg_w_enable;
            s1_wa_d    = ra;
            s1_a_d     = w_opnd_a;
            s1_b_d     = w_opnd_b;
            s1_imm_d   = imm;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '{default: '0};
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_wr_q     <= 1'b0;
            s1_wa_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_imm_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sf_q        <= 1'b0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_wr_q     <= s1_wr_d;
            s1_wa_q     <= s1_wa_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_imm_q    <= s1_imm_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sf_q        <= sf_d;
            zf_q        <= zf_d;
            cf_q        <= cf_d;
            inv_q       <= inv_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign SF         = sf_q;
    assign ZF         = zf_q;
    assign CF         = cf_q;
    assign invalid_op = inv_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_proc.sv
// +----------------------------------------------------------------------------+
// | tb_alu_pipe_proc : directed and randomized bench for alu_pipe_proc          |
// | Honours PROC_BYPASS_EN for the expected issue-bubble count.                 |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_pipe_proc;

    localparam int WIDTH = 8;
    localparam int NREGS = 16;
    localparam int AW    = 4;
`ifdef PROC_BYPASS_EN
    localparam int EXP_BUBBLES = 0;
`else
    localparam int EXP_BUBBLES = 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic sf, zf, cf, inv;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       opcode = '0;
    logic [AW-1:0]    ra = '0;
    logic [AW-1:0]    rb = '0;
    logic [WIDTH-1:0] imm = '0;
    logic             reg_w_enable = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             SF, ZF, CF, invalid_op;

    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 0;
    int unsigned ref_regs [NREGS];
    beat_t       exp_q [$];
    beat_t       obs_q [$];

    alu_pipe_proc #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .ra           (ra),
        .rb           (rb),
        .imm          (imm),
        .reg_w_enable (reg_w_enable),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .SF           (SF),
        .ZF           (ZF),
        .CF           (CF),
        .invalid_op   (invalid_op)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Records every beat that will be handed off on the coming rising edge.
    always @(negedge clk) begin
        #3;
        if (out_valid && out_ready) obs_q.push_back({result, SF, ZF, CF, invalid_op});
    end

    function automatic beat_t mk(input logic [WIDTH-1:0] r, input logic s, z, c, v);
        return {r, s, z, c, v};
    endfunction

    function automatic beat_t obs_at(input int i);
        beat_t none = 'x;
        return (i < obs_q.size()) ? obs_q[i] : none;
    endfunction

    // Architectural model: instructions take effect one at a time in issue order.
    function automatic beat_t model(input int op, input int ra_i, input int rb_i,
                                    input int imm_i, input bit we);
        int unsigned a = ref_regs[ra_i];
        int unsigned b = ref_regs[rb_i];
        int unsigned m = 1 << WIDTH;
        int unsigned v = 0;
        bit c = 0;
        bit inv = 0;
        beat_t e;
        case (op)
            0, 5: begin v = a + b; c = (v >= m); v = v % m; end
            1, 6: begin c = (a < b); v = (a + m - b) % m; end
            2:    v = a & b;
            3:    v = a | b;
            4:    v = imm_i;
            default: inv = 1;
        endcase
        e.res = v[WIDTH-1:0];
        e.sf  = (v >= m / 2);
        e.zf  = !inv && (v == 0);
        e.cf  = c;
        e.inv = inv;
        if (op >= 4 && op <= 6 && we) ref_regs[ra_i] = v;
        return e;
    endfunction

    task automatic issue(input int op, input int ra_i, input int rb_i, input int imm_i,
                         input bit we, output int stalls);
        stalls = 0;
        @(negedge clk);
        opcode       = op[2:0];
        ra           = ra_i[AW-1:0];
        rb           = rb_i[AW-1:0];
        imm          = imm_i[WIDTH-1:0];
        reg_w_enable = we;
        in_valid     = 1'b1;
        #3;
        while (!in_ready) begin
            stalls++;
            if (stalls > 200) begin
                checks++; failures++;
                $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk); #3;
        end
        exp_q.push_back(model(op, ra_i, rb_i, imm_i, we));
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #4;
            if (obs_q.size() >= exp_q.size() && !out_valid) begin ok = 1; break; end
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        #8;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        checks++; if ({result, SF, ZF, CF, invalid_op} !== '0) begin failures++;
            $display("FAIL reset_outputs got=%h required=0", {result, SF, ZF, CF, invalid_op}); end
        foreach (ref_regs[i]) ref_regs[i] = 0;
        #15 rst_n = 1'b1;
    endtask

    task automatic test_mov_addw();
        int s; bit ok;
        issue(4, 3, 0, 'h7F, 1, s);
        issue(5, 3, 3, 0, 1, s);
        idle();
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL movaddw_drain got=timeout required=drained"); end
        checks++; if (s != EXP_BUBBLES) begin failures++; $display("FAIL movaddw_bubbles got=%0d required=%0d", s, EXP_BUBBLES); end
        checks++; if (obs_at(0) !== mk('h7F, 0, 0, 0, 0)) begin failures++; $display("FAIL movaddw_beat0 got=%h required=%h", obs_at(0), mk('h7F, 0, 0, 0, 0)); end
        checks++; if (obs_at(1) !== mk('hFE, 1, 0, 0, 0)) begin failures++; $display("FAIL movaddw_beat1 got=%h required=%h", obs_at(1), mk('hFE, 1, 0, 0, 0)); end
        clear_q();
    endtask

    task automatic test_add_nowrite();
        int s; bit ok;
        issue(4, 1, 0, 'hFF, 1, s);
        issue(4, 2, 0, 'h01, 1, s);
        issue(0, 1, 2, 0, 1, s);
        issue(0, 1, 0, 0, 1, s);
        idle();
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL addnw_drain got=timeout required=drained"); end
        checks++; if (obs_at(2) !== mk('h00, 0, 1, 1, 0)) begin failures++; $display("FAIL add_carry got=%h required=%h", obs_at(2), mk('h00, 0, 1, 1, 0)); end
        checks++; if (obs_at(3) !== mk('hFF, 1, 0, 0, 0)) begin failures++; $display("FAIL add_nowrite got=%h required=%h", obs_at(3), mk('hFF, 1, 0, 0, 0)); end
        clear_q();
    endtask

    task automatic test_subw();
        int s; bit ok;
        issue(4, 1, 0, 'h05, 1, s);
        issue(4, 2, 0, 'h07, 1, s);
        issue(6, 1, 2, 0, 1, s);
        issue(0, 1, 0, 0, 0, s);
        idle();
        wait_drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL subw_drain got=timeout required=drained"); end
        checks++; if (obs_at(2) !== mk('hFE, 1, 0, 1, 0)) begin failures++; $display("FAIL subw_borrow got=%h required=%h", obs_at(2), mk('hFE, 1, 0, 1, 0)); end
        checks++; if (obs_at(3) !== mk('hFE, 1, 0, 0, 0)) begin failures++; $display("FAIL subw_written got=%h required=%h", obs_at(3), mk('hFE, 1, 0, 0, 0)); end
        clear_q();
    endtask

    task automatic test_stall();
        int ops [4] = '{0, 0, 0, 3};
        int ras [4] = '{1, 2, 3, 1};
        int rbs [4] = '{0, 0, 0, 2};
        beat_t want [4];
        int idx = 0;
        int s; bit ok;
        want[0] = mk('hFE, 1, 0, 0, 0); want[1] = mk('h07, 0, 0, 0, 0);
        want[2] = mk('hFE, 1, 0, 0, 0); want[3] = mk('hFF, 1, 0, 0, 0);
        ready_mode = 1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (idx < 4) begin
                opcode = ops[idx][2:0]; ra = ras[idx][AW-1:0]; rb = rbs[idx][AW-1:0];
                imm = '0; reg_w_enable = 1'b1; in_valid = 1'b1;
            end
            #3;
            if (cyc >= 3) begin
                checks++; if (!out_valid || {result, SF, ZF, CF, invalid_op} !== want[0]) begin failures++;
                    $display("FAIL stall_hold got=%h valid=%b required=%h", {result, SF, ZF, CF, invalid_op}, out_valid, want[0]); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ops[idx], ras[idx], rbs[idx], 0, 1));
                idx++;
            end
        end
        checks++; if (idx != 2) begin failures++; $display("FAIL stall_accepts got=%0d required=2", idx); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
        ready_mode = 0;
        while (idx < 4) begin
            issue(ops[idx], ras[idx], rbs[idx], 0, 1, s);
            idx++;
        end
        idle();
        wait_drain(ok);
        checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL stall_count got=%0d required=4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_at(i) !== want[i]) begin failures++; $display("FAIL stall_order[%0d] got=%h required=%h", i, obs_at(i), want[i]); end
        end
        clear_q();
    endtask

    task automatic test_invalid();
        int s; bit ok;
        issue(7, 1, 2, 'h33, 1, s);
        issue(4, 1, 0, 'h55, 0, s);
        issue(0, 1, 0, 0, 0, s);
        idle();
        wait_drain(ok);
        checks++; if (obs_at(0) !== mk('h00, 0, 0, 0, 1)) begin failures++; $display("FAIL invalid_beat got=%h required=%h", obs_at(0), mk('h00, 0, 0, 0, 1)); end
        checks++; if (obs_at(1) !== mk('h55, 0, 0, 0, 0)) begin failures++; $display("FAIL mov_nowe_beat got=%h required=%h", obs_at(1), mk('h55, 0, 0, 0, 0)); end
        checks++; if (obs_at(2) !== mk('hFE, 1, 0, 0, 0)) begin failures++; $display("FAIL r1_unchanged got=%h required=%h", obs_at(2), mk('hFE, 1, 0, 0, 0)); end
        clear_q();
    endtask

    task automatic test_async_reset();
        int s; bit ok;
        ready_mode = 1;
        issue(0, 1, 2, 0, 1, s);
        issue(6, 3, 2, 0, 1, s);
        idle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid got=%b required=0", out_valid); end
        checks++; if (in_ready !== 1'b1 || result !== '0) begin failures++;
            $display("FAIL async_state got in_ready=%b result=%h required 1/00", in_ready, result); end
        foreach (ref_regs[i]) ref_regs[i] = 0;
        clear_q();
        ready_mode = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        issue(0, 1, 2, 0, 1, s);
        idle();
        wait_drain(ok);
        checks++; if (obs_at(0) !== mk('h00, 0, 1, 0, 0)) begin failures++; $display("FAIL post_reset_add got=%h required=%h", obs_at(0), mk('h00, 0, 1, 0, 0)); end
        clear_q();
    endtask

    task automatic test_random();
        int s; bit ok;
        ready_mode = 2;
        for (int n = 0; n < 200; n++) begin
            issue($urandom_range(0, 7), $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                  $urandom_range(0, (1 << WIDTH) - 1), $urandom_range(0, 3) != 0, s);
            if ($urandom_range(0, 4) == 0) idle();
        end
        idle();
        ready_mode = 0;
        wait_drain(ok);
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin failures++;
            $display("FAIL rand_count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (obs_at(i) !== exp_q[i]) begin failures++;
                $display("FAIL rand_beat[%0d] got=%h required=%h", i, obs_at(i), exp_q[i]); end
        end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_mov_addw();
        test_add_nowrite();
        test_subw();
        test_stall();
        test_invalid();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_pipe_proc.md
# alu_pipe_proc

Parametrised two-stage successor to the 4-bit single-cycle processor. It accepts one instruction per cycle over a valid/ready handshake and reads operands from an internal register file. It executes ADD/SUB/AND/OR plus register-writing variants, then returns a registered result and SF/ZF/CF flags over a second valid/ready handshake. It sits between an instruction source and the downstream result consumer.

## Interface
- WIDTH, 8: datapath and register width in bits (≥2).
- NREGS, 16: register count, power of two ≥2; AW = log2(NREGS).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block accepts instruction this cycle.
- opcode  in  3  operation, see Operation.
- ra  in  AW  operand A register address; destination for writing ops.
- rb  in  AW  operand B register address.
- imm  in  WIDTH  immediate, used only by MOV.
- reg_w_enable  in  1  global write gate, sampled with the instruction.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  ALU result.
- SF, ZF, CF  out  1 each  sign, zero, carry/borrow flags of result.
- invalid_op  out  1  beat came from an invalid opcode.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR are non-writing. 100 MOV (reg[ra] ← imm), 101 ADDW, 110 SUBW write reg[ra] with the result. 111 is invalid.
- Write occurs only if opcode is writing, reg_w_enable was 1 at accept, and the op is valid.
- Arithmetic is modulo 2^WIDTH.
  - ADD CF = carry-out.
  - SUB computes A−B; CF = 1 iff A < B unsigned.
  - AND/OR/MOV have CF = 0.
- SF = result[WIDTH-1]. ZF = (result == 0).
- Invalid op: result 0, SF/ZF/CF 0, invalid_op 1, no write. A beat is still produced.
- S1 (operand stage): on accept (in_valid & in_ready), captures opcode, write flag, and operands reg[ra], reg[rb], imm.
- S2 (output stage): on S1→S2 advance, the ALU result and flags are registered into output registers and the regfile write happens on the same edge.
- Advance rules:
  - S2 advances when !out_valid | out_ready.
  - S1 advances into S2 when S1 valid and S2 can take it.
  - in_ready = !S1_valid | S1 advancing.
- Bypass: if an operand read at accept matches the address being written on the same edge, the captured operand is the write data.
- Beats leave in acceptance order, none dropped or duplicated.
- Reset: all registers and regfile are 0. in_ready = 1, out_valid = 0, result = 0, SF/ZF/CF = 0, invalid_op = 0.

## Timing
- Latency: accept at edge N → out_valid with result at edge N+1 (visible the cycle after S1 advance) when not stalled. Throughput is 1/cycle.
- Outputs are fully registered. While out_valid & !out_ready, result, flags and invalid_op hold stable.
- in_ready depends combinationally on out_ready. No other input→output combinational path exists.
- rst_n assertion clears state immediately, including mid-stall and mid-write. A write pending on that edge is lost.
- Back-to-back dependent writes (ADDW r3 then ADDW r3) produce correct chained values at full rate with bypass compiled in.

## Configuration
- PROC_BYPASS_EN defined: same-edge write→read bypass as above, with no bubbles.
- PROC_BYPASS_EN undefined:
  - No bypass mux.
  - in_ready is forced 0 for any cycle in which S1 holds a writing instruction.
  - Each writing instruction therefore costs one bubble, and reads always see committed regfile values.

## Structure
- Package proc_pkg holds:
  - the opcode enum (OP_ADD … OP_INV);
  - the is_writing() helper;
  - the opcode-width localparam.
- Sub-module alu_core (WIDTH parameter, combinational): takes op, A, B, imm and produces result, SF, ZF, CF, invalid. Instantiated once between S1 and S2.
- Regfile and pipeline registers live in the top.

## Test plan (WIDTH=8, NREGS=16)
- MOV r3←0x7F, then ADDW r3,r3 on the next cycle, out_ready=1:
  - beats 0x7F, then 0xFE with SF=1, ZF=0, CF=0;
  - with PROC_BYPASS_EN, in_ready stays 1; without it, in_ready=0 for one cycle.
- MOV r1←0xFF, MOV r2←0x01, ADD r1,r2 → 0x00, ZF=1, CF=1; a following ADD r1,r0 → 0xFF, proving ADD did not write.
- MOV r1←0x05, MOV r2←0x07, SUBW r1,r2 → 0xFE, SF=1, CF=1; then ADD r1,r0 → 0xFE.
- out_ready=0 for 6 cycles while issuing 4 instructions:
  - exactly 2 are accepted, then in_ready=0;
  - output holds the first beat stable;
  - after release, all 4 beats emerge in order.
- opcode 111 with reg_w_enable=1, ra=r1 → invalid_op=1, result 0x00, flags 0; r1 unchanged; reg_w_enable=0 on MOV also leaves r1 unchanged.
- rst_n pulsed low asynchronously while out_valid=1 and S1 full → out_valid=0 without waiting for clk; ADD r1,r2 afterwards → 0x00, ZF=1.
